fetch_unit: RTL and testbench

//  Instruction-fetch stage directly downstream of the 16-bit PC register.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bundle between fetch and imem
interface fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid,
        output addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch stage with flush; FETCH_TIMEOUT_EN adds response timeout
module fetch_unit #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_en,
    fetch_unit_if.master      imem,
    input  logic              flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              id_ready,
    output logic              fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_FULL  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              timeout;
    logic [ADDR_W-1:0] req_pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = flush ? S_IDLE : S_REQ;
            S_REQ: begin
                if (accept) begin
                    state_nxt = flush ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_nxt = imem.rsp_valid ? S_REQ : S_DRAIN;
                end else if (imem.rsp_valid) begin
                    state_nxt = S_FULL;
                end else if (timeout) begin
                    state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                if (!flush && (imem.rsp_valid || timeout)) begin
                    state_nxt = S_REQ;
                end
            end
            S_FULL: begin
                if (id_ready || flush) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        imem.req_valid = (state == S_REQ);
        imem.addr      = pc;
        accept         = (state == S_REQ) && imem.req_ready;
        pc_en          = accept || flush;
    end

    // Only a response landing in WAIT without a concurrent flush is ever captured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            req_pc   <= '0;
        end else begin
            if (accept) begin
                req_pc <= pc;
            end
            if (state == S_WAIT && imem.rsp_valid && !flush) begin
                if_valid <= 1'b1;
                if_instr <= imem.rsp_data;
                if_pc    <= req_pc;
            end else if (state == S_FULL && (id_ready || flush)) begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] timer;
    logic          waiting;

    assign waiting = (state == S_WAIT) || (state == S_DRAIN);
    assign timeout = waiting && (timer == TMAX) && !imem.rsp_valid && !flush;

    // Any state change restarts the count, so each WAIT/DRAIN visit starts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer     <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                timer <= '0;
            end else if (waiting && timer != TMAX) begin
                timer <= timer + 1'b1;
            end
            if (timeout) begin
                fetch_err <= 1'b1;
            end
        end
    end
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc;
    logic        pc_en;
    logic        flush;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready;
    logic        fetch_err;

    fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) imem_if ();

    fetch_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(15)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pc        (pc),
        .pc_en     (pc_en),
        .imem      (imem_if),
        .flush     (flush),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .id_ready  (id_ready),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    ent_t        exp_q[$];
    logic [15:0] mem [0:65535];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        int          rsp_cnt;
        logic [15:0] rsp_addr;
        logic [15:0] pc_nxt;
        logic        acc;
        int          consumed;
        ent_t        e;

        reset_n = 1'b0;
        pc = 16'h0000;
        flush = 1'b0;
        id_ready = 1'b0;
        imem_if.req_ready = 1'b0;
        imem_if.rsp_valid = 1'b0;
        imem_if.rsp_data  = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

        // 1: reset held three cycles
        cyc(); cyc(); cyc();
        settle();
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_instr", {16'd0, if_instr}, 32'd0);
        chk("rst_if_pc", {16'd0, if_pc}, 32'd0);
        chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_req_valid", {31'd0, imem_if.req_valid}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
        cyc();
        reset_n = 1'b1;
        settle();
        chk("idle_req_valid", {31'd0, imem_if.req_valid}, 32'd0);
        cyc();
        settle();
        chk("first_req_valid", {31'd0, imem_if.req_valid}, 32'd1);

        // 2: basic fetch with response two cycles after accept
        cyc();
        pc = 16'h0010; imem_if.req_ready = 1'b1;
        settle();
        chk("t2_addr", {16'd0, imem_if.addr}, 32'h0010);
        chk("t2_pc_en_accept", {31'd0, pc_en}, 32'd1);
        cyc();
        pc = 16'h0011; imem_if.req_ready = 1'b0;
        settle();
        chk("t2_pc_en_wait", {31'd0, pc_en}, 32'd0);
        chk("t2_req_valid_wait", {31'd0, imem_if.req_valid}, 32'd0);
        cyc();
        imem_if.rsp_valid = 1'b1; imem_if.rsp_data = 16'hA5C3;
        cyc();
        imem_if.rsp_valid = 1'b0; id_ready = 1'b1;
        settle();
        chk("t2_if_valid", {31'd0, if_valid}, 32'd1);
        chk("t2_if_instr", {16'd0, if_instr}, 32'hA5C3);
        chk("t2_if_pc", {16'd0, if_pc}, 32'h0010);
        chk("t2_pc_en_full", {31'd0, pc_en}, 32'd0);
        cyc();
        id_ready = 1'b0;
        settle();
        chk("t2_if_valid_drop", {31'd0, if_valid}, 32'd0);
        chk("t2_next_req", {31'd0, imem_if.req_valid}, 32'd1);
        chk("t2_next_addr", {16'd0, imem_if.addr}, 32'h0011);

        // 3: decode stall in FULL
        imem_if.req_ready = 1'b1;
        cyc();
        pc = 16'h0012; imem_if.req_ready = 1'b0;
        imem_if.rsp_valid = 1'b1; imem_if.rsp_data = 16'h1234;
        cyc();
        imem_if.rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t3_stall_instr", {16'd0, if_instr}, 32'h1234);
            chk("t3_stall_pc", {16'd0, if_pc}, 32'h0011);
            chk("t3_stall_req", {31'd0, imem_if.req_valid}, 32'd0);
            chk("t3_stall_pc_en", {31'd0, pc_en}, 32'd0);
            cyc();
        end
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        settle();
        chk("t3_resume_req", {31'd0, imem_if.req_valid}, 32'd1);
        chk("t3_resume_addr", {16'd0, imem_if.addr}, 32'h0012);

        // 4: flush in WAIT, stale response discarded
        imem_if.req_ready = 1'b1;
        cyc();
        pc = 16'h0013; imem_if.req_ready = 1'b0; flush = 1'b1;
        settle();
        chk("t4_flush_pc_en", {31'd0, pc_en}, 32'd1);
        cyc();
        flush = 1'b0; pc = 16'h0200;
        imem_if.rsp_valid = 1'b1; imem_if.rsp_data = 16'hDEAD;
        settle();
        chk("t4_drain_req", {31'd0, imem_if.req_valid}, 32'd0);
        cyc();
        imem_if.rsp_valid = 1'b0;
        settle();
        chk("t4_no_dead", {31'd0, if_valid}, 32'd0);
        chk("t4_instr_kept", {16'd0, if_instr}, 32'h1234);
        chk("t4_redirect_req", {31'd0, imem_if.req_valid}, 32'd1);
        chk("t4_redirect_addr", {16'd0, imem_if.addr}, 32'h0200);
        imem_if.req_ready = 1'b1;
        cyc();
        pc = 16'h0201; imem_if.req_ready = 1'b0;
        imem_if.rsp_valid = 1'b1; imem_if.rsp_data = 16'hBEEF;
        cyc();
        imem_if.rsp_valid = 1'b0; id_ready = 1'b1;
        settle();
        chk("t4_new_instr", {16'd0, if_instr}, 32'hBEEF);
        chk("t4_new_pc", {16'd0, if_pc}, 32'h0200);
        cyc();
        id_ready = 1'b0;

        // 5: request backpressure
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t5_hold_valid", {31'd0, imem_if.req_valid}, 32'd1);
            chk("t5_hold_pc_en", {31'd0, pc_en}, 32'd0);
            chk("t5_hold_addr", {16'd0, imem_if.addr}, 32'h0201);
            cyc();
        end
        imem_if.req_ready = 1'b1;
        settle();
        chk("t5_accept_pc_en", {31'd0, pc_en}, 32'd1);
        cyc();
        pc = 16'h0202; imem_if.req_ready = 1'b0;
        settle();
        chk("t5_after_pc_en", {31'd0, pc_en}, 32'd0);
        imem_if.rsp_valid = 1'b1; imem_if.rsp_data = 16'h5555;
        cyc();
        imem_if.rsp_valid = 1'b0; id_ready = 1'b1;
        settle();
        chk("t5_if_pc", {16'd0, if_pc}, 32'h0201);
        cyc();
        id_ready = 1'b0;

        // 6: missing response
        imem_if.req_ready = 1'b1;
        cyc();
        pc = 16'h0203; imem_if.req_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            settle();
            chk("t6_wait_err", {31'd0, fetch_err}, 32'd0);
            chk("t6_wait_req", {31'd0, imem_if.req_valid}, 32'd0);
            cyc();
        end
        settle();
        chk("t6_timeout_pc_en", {31'd0, pc_en}, 32'd0);
        cyc();
        settle();
`ifdef FETCH_TIMEOUT_EN
        chk("t6_err_set", {31'd0, fetch_err}, 32'd1);
        chk("t6_rereq", {31'd0, imem_if.req_valid}, 32'd1);
        chk("t6_rereq_addr", {16'd0, imem_if.addr}, 32'h0203);
        cyc();
        settle();
        chk("t6_err_sticky", {31'd0, fetch_err}, 32'd1);
`else
        chk("t6_err_zero", {31'd0, fetch_err}, 32'd0);
        chk("t6_still_wait", {31'd0, imem_if.req_valid}, 32'd0);
        imem_if.rsp_valid = 1'b1; imem_if.rsp_data = 16'h0F0F;
        cyc();
        imem_if.rsp_valid = 1'b0; id_ready = 1'b1;
        settle();
        chk("t6_late_instr", {16'd0, if_instr}, 32'h0F0F);
        chk("t6_late_pc", {16'd0, if_pc}, 32'h0202);
        cyc();
        id_ready = 1'b0;
`endif

        // random phase: bench acts as PC register, imem and decode
        rsp_cnt  = 0;
        rsp_addr = 16'h0000;
        consumed = 0;
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            flush             = ($urandom_range(0, 7) == 0);
            id_ready          = ($urandom_range(0, 1) == 1);
            imem_if.req_ready = ($urandom_range(0, 2) != 0);
            if (rsp_cnt == 1) begin
                imem_if.rsp_valid = 1'b1;
                imem_if.rsp_data  = mem[rsp_addr];
            end else if (rsp_cnt == 0 && $urandom_range(0, 7) == 0) begin
                imem_if.rsp_valid = 1'b1;
                imem_if.rsp_data  = 16'($urandom);
            end else begin
                imem_if.rsp_valid = 1'b0;
                imem_if.rsp_data  = 16'($urandom);
            end
            settle();
            acc = imem_if.req_valid && imem_if.req_ready;
            chk("rnd_pc_en", {31'd0, pc_en}, {31'd0, acc | flush});
            if (imem_if.req_valid) chk("rnd_addr", {16'd0, imem_if.addr}, {16'd0, pc});
            if (if_valid) begin
                chk("rnd_valid_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    chk("rnd_if_pc", {16'd0, if_pc}, {16'd0, exp_q[0].a});
                    chk("rnd_if_instr", {16'd0, if_instr}, {16'd0, exp_q[0].d});
                end
            end
            if (rsp_cnt > 0) rsp_cnt--;
            if (acc) begin
                rsp_cnt  = $urandom_range(1, 4);
                rsp_addr = pc;
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (if_valid && id_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    consumed++;
                end
                if (acc) begin
                    e.a = pc;
                    e.d = mem[pc];
                    exp_q.push_back(e);
                end
            end
            pc_nxt = pc;
            if (pc_en) pc_nxt = flush ? 16'($urandom) : pc + 16'd1;
            cyc();
            pc = pc_nxt;
        end
        chk("rnd_progress", {31'd0, consumed > 50}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
